nor_eval_pipe: RTL and testbench
================================

// Module: nor_eval_pipe
// PURPOSE
//  Pipelined, parametrised two-level NOR logic evaluator. It computes one of four
//  NOR-network functions bitwise on WIDTH-bit operands x, y, z.
//  Transfers use valid/ready handshakes on input and output, with full backpressure.
//  It sits between an operand source and a result sink, and counts delivered results.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=1)
//  CNT_W   8  width of delivered-result counter (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand word valid
//  in_ready   out  1      block accepts operand word this cycle
//  mode       in   2      function select, sampled with operands
//  x          in   WIDTH  operand x
//  y          in   WIDTH  operand y
//  z          in   WIDTH  operand z
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result this cycle
//  result     out  WIDTH  evaluated result
//  res_mode   out  2      mode that produced result
//  res_cnt    out  CNT_W  count of completed output handshakes, wraps
// BEHAVIOUR
//  Functions are bitwise: mode0 NOR(NOR(x,y),z) = (x|y)&~z; mode1 NOR(NOR(y,z),x) = (y|z)&~x.
//  mode2 NOR(NOR(x,z),y) = (x|z)&~y; mode3 NOR3(x,y,z) = ~(x|y|z).
//  Stage 1 registers the inner NOR term, the remaining operand and mode, with s1_v.
//   For mode3, the inner term is NOR(x,y) and the outer operand is z;
//   the outer op is an AND with the inner NOR, giving ~(x|y|z).
//  Stage 2 registers result and res_mode with s2_v. out_valid = s2_v.
//  Enables: en2 = !s2_v | out_ready; en1 = !s1_v | en2; in_ready = en1 (combinational).
//  Input handshake: in_valid & in_ready loads stage 1, s1_v <= 1.
//   With en1 and !in_valid, s1_v <= 0.
//  en2 loads stage 2 from stage 1, s2_v <= s1_v.
//  Latency: 2 clk from input handshake to out_valid, with no stall. Throughput 1/clk.
//  Stall: with out_valid & !out_ready, result and res_mode are held stable.
//   Stage 1 holds if full; in_ready drops once both stages are full.
//  No bubbles or drops: every accepted word appears exactly once, in order.
//  Simultaneous out handshake and new input at full occupancy: both stages advance the same cycle.
//  res_cnt increments on each out_valid & out_ready. It wraps 2^CNT_W-1 -> 0.
//  Reset (rst_n low, any time, async): s1_v = s2_v = 0, out_valid = 0, result = 0,
//   res_mode = 0, res_cnt = 0. in_ready = 1 after reset.
//   In-flight words are discarded, and no partial result is emitted.
//  x/y/z/mode are don't-care when in_valid = 0. Outputs are registered except in_ready.
// TESTING
//  T1 functions: x=F0,y=0F,z=3C, modes 0..3 back to back, out_ready=1
//   -> results C3,0F,F0,00 with res_mode 0..3, each 2 clk after accept.
//  T2 all-zero: x=y=z=00, mode3 -> FF; mode0 -> 00.
//   Also x=y=z=FF, modes 0..3 -> 00 each.
//  T3 backpressure: stream 4 words, out_ready=0 for 5 clk
//   -> in_ready low after 2 accepts, result held stable; release -> 4 results in order, no loss.
//  T4 wrap: CNT_W=2, 5 handshakes -> res_cnt 1,2,3,0,1.
//  T5 reset mid-flight: assert rst_n=0 with both stages full, async
//   -> out_valid, result, res_cnt = 0 immediately; no stale output after release.
//  T6 random: random in_valid/out_ready/operands vs reference model
//   -> result sequence matches, no duplicates or drops.

Source files
------------

// File: rtl/nor_eval_pipe.sv
// Two-stage valid/ready pipeline that evaluates one of four bitwise two-level NOR
// networks on x, y, z, and counts results delivered to the sink.
module nor_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       res_mode,
  output logic [CNT_W-1:0] res_cnt
);

  typedef enum logic [1:0] {
    FN_XY_Z = 2'd0,  // (x|y) & ~z
    FN_YZ_X = 2'd1,  // (y|z) & ~x
    FN_XZ_Y = 2'd2,  // (x|z) & ~y
    FN_NOR3 = 2'd3   // ~(x|y|z)
  } fn_e;

  logic             s1_v, s2_v;
  logic [WIDTH-1:0] s1_inner, s1_outer;
  fn_e              s1_fn;
  logic             en1, en2;
  logic [WIDTH-1:0] inner_d, outer_d, result_d;
  fn_e              fn_d;

  assign en2       = !s2_v || out_ready;
  assign en1       = !s1_v || en2;
  assign in_ready  = en1;
  assign out_valid = s2_v;
  assign fn_d      = fn_e'(mode);

  // Inner NOR over two operands; the third operand is carried to stage 2.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inner_d = ~(x | y);
    outer_d = z;
    unique case (fn_d)
      FN_YZ_X: begin inner_d = ~(y | z); outer_d = x; end
      FN_XZ_Y: begin inner_d = ~(x | z); outer_d = y; end
      default: ;
    endcase
  end

  // NOR3 folds the outer operand in as an AND with its complement.
  always_comb begin
    result_d = ~(s1_inner | s1_outer);
    if (s1_fn == FN_NOR3) result_d = s1_inner & ~s1_outer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset as well, because result must read zero out of reset.
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_inner <= '0;
      s1_outer <= '0;
      s1_fn    <= FN_XY_Z;
    end else if (en1) begin
      // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_inner <= inner_d;
        s1_outer <= outer_d;
        s1_fn    <= fn_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      result   <= '0;
      res_mode <= 2'd0;
    end else if (en2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result   <= result_d;
        res_mode <= s1_fn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                res_cnt <= '0;
    else if (s2_v && out_ready) res_cnt <= res_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_nor_eval_pipe.sv
// Self-checking bench for nor_eval_pipe: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_nor_eval_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] x = '0, y = '0, z = '0;

  logic         in_ready, out_valid;
  logic [W-1:0] result;
  logic [1:0]   res_mode;
  logic [7:0]   res_cnt;

  logic         in_ready2, out_valid2;
  logic [W-1:0] result2;
  logic [1:0]   res_mode2;
  logic [1:0]   res_cnt2;

  always #5 clk = ~clk;

  nor_eval_pipe #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_mode(res_mode), .res_cnt(res_cnt)
  );

  // Narrow-counter instance sharing all inputs, used to observe counter wrap.
  nor_eval_pipe #(.WIDTH(W), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .mode(mode),
    .x(x), .y(y), .z(z), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .res_mode(res_mode2), .res_cnt(res_cnt2)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] eval(input logic [1:0] m, input logic [W-1:0] a, b, c);
    case (m)
      2'd0:    return (a | b) & ~c;
      2'd1:    return (b | c) & ~a;
      2'd2:    return (a | c) & ~b;
      default: return ~(a | b | c);
    endcase
  endfunction

  // Reference model: in-flight words in order, each stamped with its accept cycle.
  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] r;
    int           t;
  } item_t;

  item_t mq[$];
  int    cyc = 0;
  int    hs_cnt = 0;

  function automatic bit model_valid();
    return (mq.size() > 0) && (cyc - mq[0].t >= 2);
  endfunction

  function automatic bit exp_ready();
    return (mq.size() < 2) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cyc    <= 0;
      hs_cnt <= 0;
    end else begin
      if (in_valid && exp_ready()) mq.push_back('{mode, eval(mode, x, y, z), cyc});
      if (model_valid() && out_ready) begin
        void'(mq.pop_front());
        hs_cnt <= hs_cnt + 1;
      end
      cyc <= cyc + 1;
    end
  end

  // Observed traffic, for in-order/no-loss checks in the directed tests.
  logic [W-1:0] got[$];
  int acc_n = 0;
  int out_n = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_n <= acc_n + 1;
      if (out_valid && out_ready) begin
        got.push_back(result);
        out_n <= out_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, model_valid());
    if (model_valid()) begin
      check("result", result, mq[0].r);
      check("res_mode", res_mode, mq[0].m);
    end
    if (!rst_n) check("result_in_reset", result, 0);
    check("in_ready", in_ready, exp_ready());
    check("res_cnt", res_cnt, hs_cnt[7:0]);
    check("res_cnt_w2", res_cnt2, hs_cnt[1:0]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] a, b, c);
    in_valid = 1'b1;
    mode = m; x = a; y = b; z = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready never rose, required within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic check_got(input string name, input logic [W-1:0] exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp[$];
    logic [1:0]   exp_cnt[5];
    int           a0, o0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_res_mode", res_mode, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Pin the model's function table to hand-computed values.
    check("model_m0", eval(2'd0, 8'hF0, 8'h0F, 8'h3C), 8'hC3);
    check("model_m3", eval(2'd3, 8'h00, 8'h00, 8'h00), 8'hFF);

    // T1: the four functions back to back.
    got.delete();
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) send(2'(m), 8'hF0, 8'h0F, 8'h3C);
    repeat (3) step();
    exp = '{8'hC3, 8'h0F, 8'hF0, 8'h00};
    check_got("t1", exp);

    // T2: all-zero and all-one operands.
    got.delete();
    send(2'd3, 8'h00, 8'h00, 8'h00);
    send(2'd0, 8'h00, 8'h00, 8'h00);
    for (int m = 0; m < 4; m++) send(2'(m), 8'hFF, 8'hFF, 8'hFF);
    repeat (3) step();
    exp = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_got("t2", exp);

    // T3: backpressure with both stages full, then release.
    got.delete();
    out_ready = 1'b0;
    send(2'd0, 8'hF0, 8'h0F, 8'h3C);
    send(2'd1, 8'hF0, 8'h0F, 8'h3C);
    in_valid = 1'b1;
    mode = 2'd2; x = 8'hF0; y = 8'h0F; z = 8'h3C;
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_out_valid", out_valid, 1);
      check("t3_held_result", result, 8'hC3);
      check("t3_held_mode", res_mode, 0);
      step();
    end
    out_ready = 1'b1;
    send(2'd2, 8'hF0, 8'h0F, 8'h3C);
    send(2'd3, 8'hF0, 8'h0F, 8'h3C);
    repeat (3) step();
    exp = '{8'hC3, 8'h0F, 8'hF0, 8'h00};
    check_got("t3", exp);

    // T5: asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(2'd0, 8'hF0, 8'h0F, 8'h3C);
    send(2'd3, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check("t5_full_valid", out_valid, 1);
    check("t5_full_ready", in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_result", result, 0);
    check("t5_res_cnt", res_cnt, 0);
    check("t5_res_cnt_w2", res_cnt2, 0);
    check("t5_in_ready", in_ready, 1);
    got.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    check("t5_no_stale", got.size(), 0);

    // T4: 2-bit counter wrap across five handshakes.
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      send(2'(i), 8'(i * 37), 8'(i * 11), 8'h5A);
      repeat (2) step();
      check($sformatf("t4_cnt_w2_%0d", i), res_cnt2, exp_cnt[i]);
      check($sformatf("t4_cnt_%0d", i), res_cnt, i + 1);
    end

    // T6: random traffic, checked cycle by cycle against the model.
    a0 = acc_n;
    o0 = out_n;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("t6_model_drained", mq.size(), 0);
    check("t6_out_idle", out_valid, 0);
    check("t6_no_loss", out_n - o0, acc_n - a0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
